setup_config: RTL and testbench

//  Setup-menu sequencer for the door lock. Entered when operacional raises setup_on (master PIN accepted).

---
 rtl/door_pkg.sv | 51 +++++
 rtl/sec_to_ticks.sv | 25 ++
 rtl/setup_config.sv | 228 ++++++++++++++++++++++
 tb/tb_setup_config.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/door_pkg.sv
// Shared types and constants for the door-lock controller: configuration
// packet, PIN record, six-digit display packet and keypad codes.
package door_pkg;

  typedef struct packed {
    logic       status;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
  } pinPac_t;

  typedef struct packed {
    logic        bip_status;
    logic [15:0] bip_time;
    logic [15:0] tranca_aut_time;
    pinPac_t     master_pin;
    pinPac_t     pin1;
    pinPac_t     pin2;
    pinPac_t     pin3;
    pinPac_t     pin4;
  } setupPac_t;

  typedef struct packed {
    logic [3:0] BCD5;
    logic [3:0] BCD4;
    logic [3:0] BCD3;
    logic [3:0] BCD2;
    logic [3:0] BCD1;
    logic [3:0] BCD0;
  } bcdPac_t;

  localparam logic [3:0] KEY_DIS   = 4'hA;
  localparam logic [3:0] KEY_ABORT = 4'hE;
  localparam logic [3:0] KEY_ENTER = 4'hF;
  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_ERR   = 4'hE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ITEM,
    ST_COMMIT,
    ST_ABORT,
    ST_WAIT_LOW
  } setup_state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/sec_to_ticks.sv
// Converts a two-digit BCD seconds entry into clock ticks (1 kHz clock, so
// ticks = seconds * 1000) and flags whether it lies in the accepted range.
module sec_to_ticks #(
  parameter int T_MIN_S = 5,
  parameter int T_MAX_S = 60
) (
  input  logic [3:0]  tens,
  input  logic [3:0]  ones,
  output logic        in_range,
  output logic [15:0] ticks
);

  logic [6:0]  seconds;
  logic [16:0] ticks_wide;

  // Decimal value, range test and tick conversion; out-of-range values may
  // overflow 16 bits but are never stored.
  always_comb begin
    seconds    = 7'({3'b000, tens}) * 7'd10 + 7'({3'b000, ones});
    in_range   = (seconds >= 7'(T_MIN_S)) && (seconds <= 7'(T_MAX_S));
    ticks_wide = 17'(seconds) * 17'd1000;
    ticks      = ticks_wide[15:0];
  end

endmodule

// File: rtl/setup_config.sv
// Setup-menu sequencer: walks the user through seven configuration items on
// the keypad, edits a shadow copy of the current configuration, and either
// commits it or aborts, signalling the end of the session with one pulse.
module setup_config
  import door_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 30000,
  parameter int T_MIN_S       = 5,
  parameter int T_MAX_S       = 60,
  parameter int ERR_TICKS     = 1000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      setup_on,
  input  logic      key_valid,
  input  logic [3:0] key_code,
  input  setupPac_t data_setup_old,
  output setupPac_t data_setup_new,
  output logic      setup_end,
  output logic      setup_valid,
  output bcdPac_t   bcd_out,
  output logic      bcd_enable
);

  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
  localparam int ER_W = $clog2(ERR_TICKS + 1);
  localparam logic [15:0] T_MIN_TICKS = 16'(T_MIN_S * 1000);

  function automatic setupPac_t reset_cfg();
    setupPac_t c;
    c                 = '0;
    c.bip_status      = 1'b1;
    c.bip_time        = T_MIN_TICKS;
    c.tranca_aut_time = T_MIN_TICKS;
    return c;
  endfunction

  setup_state_t    state;
  logic [2:0]      item;
  setupPac_t       shadow;
  logic [3:0][3:0] dig_buf;   // [0] is the most recent digit
  logic [2:0]      dig_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [ER_W-1:0] err_cnt;

  logic [2:0]  dig_cap;
  logic [3:0]  tens_in;
  logic        sec_ok;
  logic [15:0] sec_ticks;
  pinPac_t     cur_pin;
  pinPac_t     pin_upd;
  setupPac_t   shadow_upd;
  setupPac_t   commit_cfg;
  logic        advance;
  logic        reject;

  sec_to_ticks #(
    .T_MIN_S (T_MIN_S),
    .T_MAX_S (T_MAX_S)
  ) u_sec_to_ticks (
    .tens     (tens_in),
    .ones     (dig_buf[0]),
    .in_range (sec_ok),
    .ticks    (sec_ticks)
  );

  // Buffer depth per item and the tens digit seen by the seconds converter.
  always_comb begin
    if (item == 3'd1)      dig_cap = 3'd1;
    else if (item <= 3'd3) dig_cap = 3'd2;
    else                   dig_cap = 3'd4;
    tens_in = (dig_cnt >= 3'd2) ? dig_buf[1] : 4'd0;
  end

  // Decode the current key against the current item: new shadow value and
  // whether it advances, is rejected, or neither (digits, ignored keys).
  always_comb begin
    cur_pin = shadow.pin4;
    case (item)
      3'd4:    cur_pin = shadow.pin1;
      3'd5:    cur_pin = shadow.pin2;
      3'd6:    cur_pin = shadow.pin3;
      default: cur_pin = shadow.pin4;
    endcase
    pin_upd    = cur_pin;
    shadow_upd = shadow;
    advance    = 1'b0;
    reject     = 1'b0;
    if (key_code == KEY_ENTER) begin
      if (dig_cnt == 3'd0) begin
        advance = 1'b1;
      end else begin
        case (item)
          3'd1: begin
            if (dig_buf[0] <= 4'd1) begin
              shadow_upd.bip_status = dig_buf[0][0];
              advance = 1'b1;
            end else reject = 1'b1;
          end
          3'd2: begin
            if (sec_ok) begin
              shadow_upd.bip_time = sec_ticks;
              advance = 1'b1;
            end else reject = 1'b1;
          end
          3'd3: begin
            if (sec_ok) begin
              shadow_upd.tranca_aut_time = sec_ticks;
              advance = 1'b1;
            end else reject = 1'b1;
          end
          default: begin
            if (dig_cnt == 3'd4 &&
                dig_buf != {shadow.master_pin.digit1, shadow.master_pin.digit2,
                            shadow.master_pin.digit3, shadow.master_pin.digit4}) begin
              pin_upd = {1'b1, dig_buf};
              advance = 1'b1;
            end else reject = 1'b1;
          end
        endcase
      end
    end else if (key_code == KEY_DIS && item >= 3'd4) begin
      pin_upd.status = 1'b0;
      advance        = 1'b1;
    end
    case (item)
      3'd4:    shadow_upd.pin1 = pin_upd;
      3'd5:    shadow_upd.pin2 = pin_upd;
      3'd6:    shadow_upd.pin3 = pin_upd;
      3'd7:    shadow_upd.pin4 = pin_upd;
      default: ;
    endcase
    commit_cfg            = shadow_upd;
    commit_cfg.master_pin = data_setup_old.master_pin;
  end

  // Session FSM with shadow, digit buffer, timeout and error counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      item           <= 3'd1;
      dig_cnt        <= 3'd0;
      to_cnt         <= '0;
      err_cnt        <= '0;
      setup_end      <= 1'b0;
      setup_valid    <= 1'b0;
      data_setup_new <= reset_cfg();
    end else begin
      setup_end   <= 1'b0;
      setup_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (setup_on) begin
            shadow  <= data_setup_old;
            item    <= 3'd1;
            dig_cnt <= 3'd0;
            to_cnt  <= '0;
            err_cnt <= '0;
            state   <= ST_ITEM;
          end
        end
        ST_ITEM: begin
          if (!setup_on) begin
            err_cnt <= '0;
            state   <= ST_IDLE;
          end else if (key_valid) begin
            to_cnt  <= '0;
            err_cnt <= '0;
            if (key_code == KEY_ABORT) begin
              state     <= ST_ABORT;
              setup_end <= 1'b1;
            end else if (advance) begin
              shadow  <= shadow_upd;
              dig_cnt <= 3'd0;
              if (item == 3'd7) begin
                state          <= ST_COMMIT;
                setup_end      <= 1'b1;
                setup_valid    <= 1'b1;
                data_setup_new <= commit_cfg;
              end else begin
                item <= item + 3'd1;
              end
            end else if (reject) begin
              dig_cnt <= 3'd0;
              err_cnt <= ER_W'(ERR_TICKS);
            end else if (is_digit(key_code)) begin
              dig_buf <= {dig_buf[2:0], key_code};
              if (dig_cnt < dig_cap) dig_cnt <= dig_cnt + 3'd1;
            end
          end else begin
            if (err_cnt != '0) err_cnt <= err_cnt - ER_W'(1);
            if (to_cnt == TO_W'(TIMEOUT_TICKS - 1)) begin
              err_cnt   <= '0;
              state     <= ST_ABORT;
              setup_end <= 1'b1;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
        end
        ST_COMMIT, ST_ABORT: state <= ST_WAIT_LOW;
        ST_WAIT_LOW: if (!setup_on) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Display mux: item number, right-aligned digits or the error pattern.
  always_comb begin
    bcd_enable = (state == ST_ITEM) || (state == ST_COMMIT) || (state == ST_ABORT);
    bcd_out    = {6{BCD_BLANK}};
    if (state == ST_ITEM) begin
      bcd_out.BCD5 = {1'b0, item};
      if (err_cnt != '0) begin
        bcd_out.BCD3 = BCD_ERR;
        bcd_out.BCD2 = BCD_ERR;
        bcd_out.BCD1 = BCD_ERR;
        bcd_out.BCD0 = BCD_ERR;
      end else begin
        if (dig_cnt >= 3'd1) bcd_out.BCD0 = dig_buf[0];
        if (dig_cnt >= 3'd2) bcd_out.BCD1 = dig_buf[1];
        if (dig_cnt >= 3'd3) bcd_out.BCD2 = dig_buf[2];
        if (dig_cnt >= 3'd4) bcd_out.BCD3 = dig_buf[3];
      end
    end
  end

endmodule

// File: tb/tb_setup_config.sv
// Directed bench for setup_config: full walk-through, per-item acceptance and
// rejection, error display, abort, timeout and reset mid-session.
module tb_setup_config;
  import door_pkg::*;

  localparam int TO = 300;
  localparam int ER = 20;

  logic       clk;
  logic       rst;
  logic       setup_on;
  logic       key_valid;
  logic [3:0] key_code;
  setupPac_t  data_setup_old;
  setupPac_t  data_setup_new;
  logic       setup_end;
  logic       setup_valid;
  bcdPac_t    bcd_out;
  logic       bcd_enable;

  setupPac_t  rst_cfg;
  setupPac_t  exp_cfg;
  int         n_chk;
  int         n_pass;
  int         n_end;
  int         e0;

  setup_config #(
    .TIMEOUT_TICKS (TO),
    .T_MIN_S       (5),
    .T_MAX_S       (60),
    .ERR_TICKS     (ER)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .setup_on       (setup_on),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .data_setup_old (data_setup_old),
    .data_setup_new (data_setup_new),
    .setup_end      (setup_end),
    .setup_valid    (setup_valid),
    .bcd_out        (bcd_out),
    .bcd_enable     (bcd_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (setup_end === 1'b1) n_end++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic enter_setup();
    setup_on = 1'b1;
    cyc(1);
  endtask

  task automatic leave_setup();
    setup_on = 1'b0;
    cyc(2);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_end = 0;
    rst = 1'b1; setup_on = 1'b0; key_valid = 1'b0; key_code = 4'h0;

    data_setup_old                 = '0;
    data_setup_old.bip_status      = 1'b0;
    data_setup_old.bip_time        = 16'd10000;
    data_setup_old.tranca_aut_time = 16'd20000;
    data_setup_old.master_pin      = '{1'b1, 4'd4, 4'd3, 4'd2, 4'd1};
    data_setup_old.pin1            = '{1'b0, 4'd0, 4'd0, 4'd0, 4'd0};
    data_setup_old.pin2            = '{1'b1, 4'd7, 4'd7, 4'd7, 4'd7};
    data_setup_old.pin3            = '{1'b0, 4'd1, 4'd1, 4'd1, 4'd1};
    data_setup_old.pin4            = '{1'b1, 4'd9, 4'd8, 4'd7, 4'd6};

    rst_cfg                 = '0;
    rst_cfg.bip_status      = 1'b1;
    rst_cfg.bip_time        = 16'd5000;
    rst_cfg.tranca_aut_time = 16'd5000;

    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk("rst_end",   128'(setup_end),      128'(0));
    chk("rst_valid", 128'(setup_valid),    128'(0));
    chk("rst_en",    128'(bcd_enable),     128'(0));
    chk("rst_bcd",   128'(bcd_out),        128'(24'hFFFFFF));
    chk("rst_cfg",   128'(data_setup_new), 128'(rst_cfg));

    // Session 1: enter on every item keeps the old configuration.
    enter_setup();
    chk("s1_en",  128'(bcd_enable), 128'(1));
    chk("s1_bcd", 128'(bcd_out),    128'(24'h1FFFFF));
    repeat (7) press(KEY_ENTER);
    chk("s1_end",   128'(setup_end),      128'(1));
    chk("s1_valid", 128'(setup_valid),    128'(1));
    chk("s1_cfg",   128'(data_setup_new), 128'(data_setup_old));
    cyc(1);
    chk("s1_end_low", 128'(setup_end),  128'(0));
    chk("s1_waitlow", 128'(bcd_enable), 128'(0));
    leave_setup();

    // Session 2: edits, rejections and error display.
    exp_cfg      = data_setup_old;
    exp_cfg.bip_status      = 1'b1;
    exp_cfg.bip_time        = 16'd12000;
    exp_cfg.tranca_aut_time = 16'd30000;
    exp_cfg.pin1            = '{1'b1, 4'd5, 4'd5, 4'd5, 4'd5};
    exp_cfg.pin2            = '{1'b0, 4'd7, 4'd7, 4'd7, 4'd7};
    exp_cfg.pin4            = '{1'b1, 4'd3, 4'd4, 4'd5, 4'd6};

    enter_setup();
    press(4'd0); press(4'd1);
    chk("i1_ovf", 128'(bcd_out), 128'(24'h1FFFF1));
    press(KEY_ENTER);
    chk("i2_enter", 128'(bcd_out), 128'(24'h2FFFFF));
    press(4'd0); press(4'd4); press(KEY_ENTER);
    chk("i2_low_rej", 128'(bcd_out), 128'(24'h2FEEEE));
    press(4'd6); press(4'd1);
    chk("i2_buf61", 128'(bcd_out), 128'(24'h2FFF61));
    press(KEY_ENTER);
    chk("i2_high_rej", 128'(bcd_out), 128'(24'h2FEEEE));
    press(4'd1); press(4'd2);
    chk("i2_buf12", 128'(bcd_out), 128'(24'h2FFF12));
    press(KEY_ENTER);
    chk("i3_enter", 128'(bcd_out), 128'(24'h3FFFFF));
    press(4'd9); press(4'd9); press(KEY_ENTER);
    chk("i3_rej", 128'(bcd_out), 128'(24'h3FEEEE));
    cyc(ER - 1);
    chk("i3_err_hold", 128'(bcd_out), 128'(24'h3FEEEE));
    cyc(1);
    chk("i3_err_done", 128'(bcd_out), 128'(24'h3FFFFF));
    press(KEY_DIS);
    chk("i3_dis_ign", 128'(bcd_out), 128'(24'h3FFFFF));
    press(4'd3); press(4'd0); press(KEY_ENTER);
    chk("i4_enter", 128'(bcd_out), 128'(24'h4FFFFF));
    press(4'd1); press(4'd2); press(KEY_ENTER);
    chk("i4_short_rej", 128'(bcd_out), 128'(24'h4FEEEE));
    press(4'd4);
    chk("i4_err_early", 128'(bcd_out), 128'(24'h4FFFF4));
    press(4'd3); press(4'd2); press(4'd1);
    chk("i4_buf", 128'(bcd_out), 128'(24'h4F4321));
    press(KEY_ENTER);
    chk("i4_master_rej", 128'(bcd_out), 128'(24'h4FEEEE));
    repeat (4) press(4'd5);
    press(KEY_ENTER);
    chk("i5_enter", 128'(bcd_out), 128'(24'h5FFFFF));
    press(KEY_DIS);
    chk("i6_dis", 128'(bcd_out), 128'(24'h6FFFFF));
    press(KEY_ENTER);
    chk("i7_enter", 128'(bcd_out), 128'(24'h7FFFFF));
    for (int d = 1; d <= 6; d++) press(4'(d));
    chk("i7_ovf", 128'(bcd_out), 128'(24'h7F3456));
    press(KEY_ENTER);
    chk("s2_end",   128'(setup_end),      128'(1));
    chk("s2_valid", 128'(setup_valid),    128'(1));
    chk("s2_cfg",   128'(data_setup_new), 128'(exp_cfg));
    leave_setup();

    // Session 3: abort on item 2.
    enter_setup();
    press(KEY_ENTER);
    e0 = n_end;
    press(KEY_ABORT);
    chk("ab_end",   128'(setup_end),      128'(1));
    chk("ab_valid", 128'(setup_valid),    128'(0));
    chk("ab_cfg",   128'(data_setup_new), 128'(exp_cfg));
    cyc(10);
    chk("ab_one_pulse", 128'(n_end - e0), 128'(1));
    chk("ab_waitlow",   128'(bcd_enable), 128'(0));
    leave_setup();

    // Session 4: inactivity timeout.
    enter_setup();
    cyc(TO - 1);
    chk("to_before", 128'(setup_end), 128'(0));
    cyc(1);
    chk("to_end",   128'(setup_end),   128'(1));
    chk("to_valid", 128'(setup_valid), 128'(0));
    leave_setup();

    // Session 5: a key in the expiry cycle restarts the timeout.
    enter_setup();
    cyc(TO - 1);
    press(4'hB);
    chk("tk_noabort", 128'(setup_end),  128'(0));
    chk("tk_active",  128'(bcd_enable), 128'(1));
    cyc(TO - 1);
    chk("tk_before", 128'(setup_end), 128'(0));
    cyc(1);
    chk("tk_end", 128'(setup_end), 128'(1));
    leave_setup();

    // Session 6: reset mid-session.
    enter_setup();
    press(4'd1);
    chk("rs_buf", 128'(bcd_out), 128'(24'h1FFFF1));
    e0 = n_end;
    setup_on = 1'b0;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("rs_en",  128'(bcd_enable),     128'(0));
    chk("rs_bcd", 128'(bcd_out),        128'(24'hFFFFFF));
    chk("rs_cfg", 128'(data_setup_new), 128'(rst_cfg));
    cyc(3);
    chk("rs_nopulse", 128'(n_end - e0), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
